// File: rtl/nn_pkg.sv
// Shared definitions for the nn layer sequencer and the nn core config port.
// Contents: sequencer state encoding, descriptor words per layer, and the
// config register indices used on the core's cfg port.
package nn_pkg;

  typedef enum logic [2:0] {
    NN_SEQ_IDLE  = 3'd0,
    NN_SEQ_REQ   = 3'd1,
    NN_SEQ_WAIT  = 3'd2,
    NN_SEQ_WR    = 3'd3,
    NN_SEQ_START = 3'd4,
    NN_SEQ_RUN   = 3'd5,
    NN_SEQ_FIN   = 3'd6
  } nn_seq_state_e;

  localparam int NN_DESC_WORDS = 4;

  localparam logic [1:0] NN_CFG_IDX0 = 2'd0;
  localparam logic [1:0] NN_CFG_IDX1 = 2'd1;
  localparam logic [1:0] NN_CFG_IDX2 = 2'd2;
  localparam logic [1:0] NN_CFG_IDX3 = 2'd3;

endpackage

// File: rtl/nn_layer_seq.sv
// nn_layer_seq: runs a multi-layer network on the nn core from a single start.
// For each layer it reads four descriptor words (base + 4*layer + word, address
// wraps), writes them to core config registers 0..3, pulses the core start and
// waits for finish. All outputs are registered and 0 in reset.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_abort        run request (IDLE only), abort (any non-IDLE state)
//   i_desc_base, i_layer_num  table base and layer count, captured on start
//   o_desc_rd_en/addr       descriptor read request (one-cycle pulse)
//   i_desc_rd_data/valid    descriptor read return (variable latency)
//   o_cfg, o_cfg_addr, o_cfg_wr_en  core config write port
//   o_nn_start, i_nn_finish core start pulse / finish
//   o_busy, o_done, o_err, o_layer_idx  status
//
// Build option: NN_SEQ_WDOG_EN adds a RUN-state watchdog of WDOG_WIDTH bits
// that aborts the run when it reaches all-ones.
//
// state        | meaning
// IDLE         | waiting for i_start
// REQ          | issue descriptor read for current layer/word
// WAIT         | wait for descriptor read data
// WR           | write captured word into core config register
// START        | pulse core start after cfg3
// RUN          | wait for core finish
// FIN          | pulse o_done, return to IDLE
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int CFG_WIDTH       = 16,
  parameter int DESC_ADDR_WIDTH = 12,
  parameter int LAYER_CNT_WIDTH = 8,
  parameter int WDOG_WIDTH      = 20
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [DESC_ADDR_WIDTH-1:0] i_desc_base,
  input  logic [LAYER_CNT_WIDTH-1:0] i_layer_num,
  output logic                       o_desc_rd_en,
  output logic [DESC_ADDR_WIDTH-1:0] o_desc_rd_addr,
  input  logic [CFG_WIDTH-1:0]       i_desc_rd_data,
  input  logic                       i_desc_rd_valid,
  output logic [CFG_WIDTH-1:0]       o_cfg,
  output logic [1:0]                 o_cfg_addr,
  output logic                       o_cfg_wr_en,
  output logic                       o_nn_start,
  input  logic                       i_nn_finish,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [LAYER_CNT_WIDTH-1:0] o_layer_idx
);

  nn_seq_state_e              state_q, state_d;
  logic [DESC_ADDR_WIDTH-1:0] base_q, base_d;
  logic [LAYER_CNT_WIDTH-1:0] num_q, num_d;
  logic [LAYER_CNT_WIDTH-1:0] layer_q, layer_d, layer_inc;
  logic [1:0]                 word_q, word_d;
  logic [CFG_WIDTH-1:0]       data_q, data_d;
  logic                       wdog_exp;
  logic                       stop_req;

  logic                       rd_en_d, cfg_wr_en_d, nn_start_d, busy_d, done_d, err_d;
  logic [DESC_ADDR_WIDTH-1:0] rd_addr_d;
  logic [CFG_WIDTH-1:0]       cfg_d;
  logic [1:0]                 cfg_addr_d;

`ifdef NN_SEQ_WDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_q <= '0;
    end else if (state_q == NN_SEQ_START) begin
      wdog_q <= '0;
    end else if (state_q == NN_SEQ_RUN) begin
      wdog_q <= wdog_q + WDOG_WIDTH'(1);
    end
  end

  assign wdog_exp = (state_q == NN_SEQ_RUN) && (&wdog_q);
`else
  // Watchdog compiled out: RUN waits for finish indefinitely.
  assign wdog_exp = (WDOG_WIDTH < 0);
`endif

  // Abort and watchdog expiry share one path and take priority over finish.
  assign stop_req  = (state_q != NN_SEQ_IDLE) && (i_abort || wdog_exp);
  assign layer_inc = layer_q + LAYER_CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    layer_d = layer_q;
    word_d  = word_q;
    data_d  = data_q;
    err_d   = 1'b0;
    if (stop_req) begin
      state_d = NN_SEQ_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        NN_SEQ_IDLE: begin
          if (i_start) begin
            base_d  = i_desc_base;
            num_d   = i_layer_num;
            layer_d = '0;
            word_d  = NN_CFG_IDX0;
            state_d = (i_layer_num == '0) ? NN_SEQ_FIN : NN_SEQ_REQ;
          end
        end
        NN_SEQ_REQ:  state_d = NN_SEQ_WAIT;
        NN_SEQ_WAIT: begin
          if (i_desc_rd_valid) begin
            data_d  = i_desc_rd_data;
            state_d = NN_SEQ_WR;
          end
        end
        NN_SEQ_WR: begin
          word_d  = word_q + 2'd1;
          state_d = (word_q == NN_CFG_IDX3) ? NN_SEQ_START : NN_SEQ_REQ;
        end
        NN_SEQ_START: state_d = NN_SEQ_RUN;
        NN_SEQ_RUN: begin
          if (i_nn_finish) begin
            layer_d = layer_inc;
            state_d = (layer_inc == num_q) ? NN_SEQ_FIN : NN_SEQ_REQ;
          end
        end
        NN_SEQ_FIN: state_d = NN_SEQ_IDLE;
        default:    state_d = NN_SEQ_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    rd_en_d     = (state_d == NN_SEQ_REQ);
    cfg_wr_en_d = (state_d == NN_SEQ_WR);
    nn_start_d  = (state_d == NN_SEQ_START);
    done_d      = (state_d == NN_SEQ_FIN);
    busy_d      = (state_d != NN_SEQ_IDLE);
    rd_addr_d   = o_desc_rd_addr;
    cfg_d       = o_cfg;
    cfg_addr_d  = o_cfg_addr;
    if (state_d == NN_SEQ_REQ) begin
      rd_addr_d = base_d
                + DESC_ADDR_WIDTH'(layer_d) * DESC_ADDR_WIDTH'(NN_DESC_WORDS)
                + DESC_ADDR_WIDTH'(word_d);
    end
    if (state_d == NN_SEQ_WR) begin
      cfg_d      = data_d;
      cfg_addr_d = word_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= NN_SEQ_IDLE;
      base_q         <= '0;
      num_q          <= '0;
      layer_q        <= '0;
      word_q         <= '0;
      data_q         <= '0;
      o_desc_rd_en   <= 1'b0;
      o_desc_rd_addr <= '0;
      o_cfg          <= '0;
      o_cfg_addr     <= '0;
      o_cfg_wr_en    <= 1'b0;
      o_nn_start     <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_layer_idx    <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      num_q          <= num_d;
      layer_q        <= layer_d;
      word_q         <= word_d;
      data_q         <= data_d;
      o_desc_rd_en   <= rd_en_d;
      o_desc_rd_addr <= rd_addr_d;
      o_cfg          <= cfg_d;
      o_cfg_addr     <= cfg_addr_d;
      o_cfg_wr_en    <= cfg_wr_en_d;
      o_nn_start     <= nn_start_d;
      o_busy         <= busy_d;
      o_done         <= done_d;
      o_err          <= err_d;
      o_layer_idx    <= layer_d;
    end
  end

endmodule
